// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and receiver state encoding,
// used by both the hvsync generator and the timing receiver.
package vga_pkg;

  localparam int unsigned HCntW     = 12;
  localparam int unsigned VCntW     = 11;

  localparam int unsigned HTotal    = 800;
  localparam int unsigned HSyncLen  = 96;
  localparam int unsigned HActStart = 144;
  localparam int unsigned HActLen   = 640;

  localparam int unsigned VTotal    = 525;
  localparam int unsigned VSyncLen  = 2;
  localparam int unsigned VActStart = 35;
  localparam int unsigned VActLen   = 480;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for a raw sync input, normalised to active-high,
// with single-cycle assertion and deassertion pulses.
module sync_edge_det #(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic active,
  output logic on_edge,
  output logic off_edge
);

  logic s1_q, s2_q, prev_q;

  // Polarity is folded in ahead of the first flop so the all-zero reset
  // state reads as "deasserted" and cannot fake an edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= sig_in ^ ACT_LOW;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign active   = s2_q;
  assign on_edge  = s2_q & ~prev_q;
  assign off_edge = ~s2_q & prev_q;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers hpos/vpos from incoming hsync/vsync, measures
// line/frame length and hsync width, and tracks lock to a stable timing.
module vga_timing_rx
  import vga_pkg::*;
#(
  parameter int unsigned H_CNT_W      = HCntW,
  parameter int unsigned V_CNT_W      = VCntW,
  parameter bit          SYNC_ACT_LOW = 1'b1,
  parameter int unsigned H_ACT_START  = HActStart,
  parameter int unsigned H_ACT_LEN    = HActLen,
  parameter int unsigned V_ACT_START  = VActStart,
  parameter int unsigned V_ACT_LEN    = VActLen,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic               locked,
  output logic [H_CNT_W-1:0] hpos,
  output logic [V_CNT_W-1:0] vpos,
  output logic               display_on,
  output logic               frame_start,
  output logic [H_CNT_W-1:0] h_total,
  output logic [H_CNT_W-1:0] hsync_width,
  output logic [V_CNT_W-1:0] v_total,
  output logic [7:0]         lock_err_cnt
);

  localparam int unsigned        MatchW    = $clog2(LOCK_FRAMES + 1);
  localparam logic [MatchW-1:0]  MatchLock = MatchW'(LOCK_FRAMES);
  localparam logic [H_CNT_W-1:0] HWinLo    = H_CNT_W'(H_ACT_START);
  localparam logic [H_CNT_W-1:0] HWinHi    = H_CNT_W'(H_ACT_START + H_ACT_LEN);
  localparam logic [V_CNT_W-1:0] VWinLo    = V_CNT_W'(V_ACT_START);
  localparam logic [V_CNT_W-1:0] VWinHi    = V_CNT_W'(V_ACT_START + V_ACT_LEN);

  logic hs_act, hs_edge, hs_fall;
  logic vs_act, vs_edge, vs_fall;
  logic unused_vs;

  sync_edge_det #(.ACT_LOW(SYNC_ACT_LOW)) u_hs_sync (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (hsync_in),
    .active   (hs_act),
    .on_edge  (hs_edge),
    .off_edge (hs_fall)
  );

  sync_edge_det #(.ACT_LOW(SYNC_ACT_LOW)) u_vs_sync (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (vsync_in),
    .active   (vs_act),
    .on_edge  (vs_edge),
    .off_edge (vs_fall)
  );

  assign unused_vs = vs_act ^ vs_fall;

  rx_state_t          state_q, state_d;
  logic [H_CNT_W-1:0] hpos_q, hpos_d, h_total_q, h_total_d;
  logic [H_CNT_W-1:0] hs_cnt_q, hs_cnt_d, hs_width_q, line_len;
  logic [V_CNT_W-1:0] vpos_q, vpos_d, v_total_q, v_total_d, frame_len;
  logic [MatchW-1:0]  match_q, match_d;
  logic [7:0]         err_q, err_d;
  logic               vs_pend_q, fs_q, disp_q, disp_d;
  logic               h_ref_q, h_ref_d, v_ref_q, v_ref_d, bad_q, bad_d;
  logic               h_sat, v_sat, frame_bnd, line_bad, lose;

  assign h_sat     = &hpos_q;
  assign v_sat     = &vpos_q;
  assign line_len  = hpos_q + 1'b1;
  assign frame_len = vpos_q + 1'b1;
  // A pending vsync is only applied on a later hsync edge, absorbing skew.
  assign frame_bnd = hs_edge & vs_pend_q;
  assign line_bad  = hs_edge & h_ref_q & (line_len != h_total_q);

  always_comb begin
    hpos_d = hpos_q;
    if (hs_edge)     hpos_d = '0;
    else if (!h_sat) hpos_d = hpos_q + 1'b1;

    vpos_d = vpos_q;
    if (frame_bnd)                vpos_d = '0;
    else if (hs_edge && !v_sat)   vpos_d = vpos_q + 1'b1;

    hs_cnt_d = '0;
    if (hs_edge)     hs_cnt_d = {{(H_CNT_W-1){1'b0}}, 1'b1};
    else if (hs_act) hs_cnt_d = (&hs_cnt_q) ? hs_cnt_q : hs_cnt_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    h_ref_d   = h_ref_q;
    v_ref_d   = v_ref_q;
    bad_d     = bad_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    unique case (state_q)
      SEARCH: begin
        if (frame_bnd) begin
          state_d = TRACK;
          match_d = '0;
          h_ref_d = 1'b0;
          v_ref_d = 1'b0;
          bad_d   = 1'b0;
        end
      end
      TRACK: begin
        if (hs_edge && !h_ref_q) begin
          h_total_d = line_len;
          h_ref_d   = 1'b1;
        end
        if (line_bad) bad_d = 1'b1;
        if (frame_bnd) begin
          bad_d = 1'b0;
          if (bad_q || line_bad || (v_ref_q && frame_len != v_total_q)) begin
            match_d = '0;
            h_ref_d = 1'b0;
            v_ref_d = 1'b0;
          end else if (!v_ref_q) begin
            v_total_d = frame_len;
            v_ref_d   = 1'b1;
            match_d   = '0;
          end else begin
            match_d = match_q + 1'b1;
            if (match_d == MatchLock) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (line_bad || (frame_bnd && frame_len != v_total_q) || v_sat) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
    // Lost hsync: the line counter running out overrides everything.
    if (h_sat) state_d = SEARCH;
  end

  assign lose  = (state_q == LOCKED) && (state_d != LOCKED);
  assign err_d = (lose && err_q != 8'hff) ? err_q + 8'd1 : err_q;
  assign disp_d = (state_d == LOCKED) && (hpos_d >= HWinLo) && (hpos_d < HWinHi) &&
                  (vpos_d >= VWinLo) && (vpos_d < VWinHi);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEARCH;
      hpos_q     <= '0;
      vpos_q     <= '0;
      h_total_q  <= '0;
      v_total_q  <= '0;
      hs_cnt_q   <= '0;
      hs_width_q <= '0;
      match_q    <= '0;
      err_q      <= '0;
      vs_pend_q  <= 1'b0;
      fs_q       <= 1'b0;
      disp_q     <= 1'b0;
      h_ref_q    <= 1'b0;
      v_ref_q    <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      h_total_q  <= h_total_d;
      v_total_q  <= v_total_d;
      hs_cnt_q   <= hs_cnt_d;
      hs_width_q <= hs_fall ? hs_cnt_q : hs_width_q;
      match_q    <= match_d;
      err_q      <= err_d;
      vs_pend_q  <= vs_edge | (vs_pend_q & ~hs_edge);
      fs_q       <= frame_bnd;
      disp_q     <= disp_d;
      h_ref_q    <= h_ref_d;
      v_ref_q    <= v_ref_d;
      bad_q      <= bad_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign hpos         = hpos_q;
  assign vpos         = vpos_q;
  assign display_on   = disp_q;
  assign frame_start  = fs_q;
  assign h_total      = h_total_q;
  assign hsync_width  = hs_width_q;
  assign v_total      = v_total_q;
  assign lock_err_cnt = err_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Scoreboarded bench for vga_timing_rx using a scaled-down 100x12 raster so
// several lock/loss/relock cycles fit in a short run.
module tb_vga_timing_rx;

  localparam int HT  = 100;
  localparam int HSW = 12;
  localparam int VT  = 12;
  localparam int VSW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        locked, display_on, frame_start;
  logic [11:0] hpos, h_total, hsync_width;
  logic [10:0] vpos, v_total;
  logic [7:0]  lock_err_cnt;

  vga_timing_rx #(
    .H_ACT_START (20),
    .H_ACT_LEN   (64),
    .V_ACT_START (3),
    .V_ACT_LEN   (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .locked       (locked),
    .hpos         (hpos),
    .vpos         (vpos),
    .display_on   (display_on),
    .frame_start  (frame_start),
    .h_total      (h_total),
    .hsync_width  (hsync_width),
    .v_total      (v_total),
    .lock_err_cnt (lock_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lk;
    logic [7:0]  err;
    logic [11:0] ht;
    logic [10:0] vt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   disp_pts = 0;
  logic disp_en = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_hpos"}, 32'(hpos), 0);
    check({tag, "_vpos"}, 32'(vpos), 0);
    check({tag, "_display_on"}, 32'(display_on), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_h_total"}, 32'(h_total), 0);
    check({tag, "_hsync_width"}, 32'(hsync_width), 0);
    check({tag, "_v_total"}, 32'(v_total), 0);
    check({tag, "_lock_err_cnt"}, 32'(lock_err_cnt), 0);
  endtask

  function automatic exp_t mk(input logic lk, input int err, input int ht, input int vt);
    exp_t r;
    r.lk  = lk;
    r.err = 8'(err);
    r.ht  = 12'(ht);
    r.vt  = 11'(vt);
    return r;
  endfunction

  // Scoreboard: one record per generated frame, consumed at frame_start.
  always @(negedge clk) begin
    if (frame_start) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fb_unexpected: got frame_start pulse, expected no pending frame");
      end else begin
        e = exp_q.pop_front();
        check("fb_locked", 32'(locked), 32'(e.lk));
        check("fb_lock_err_cnt", 32'(lock_err_cnt), 32'(e.err));
        check("fb_h_total", 32'(h_total), 32'(e.ht));
        check("fb_v_total", 32'(v_total), 32'(e.vt));
        check("fb_vpos", 32'(vpos), 0);
        check("fb_hpos", 32'(hpos), 0);
        check("fb_hsync_width", 32'(hsync_width), HSW);
      end
    end
  end

  // Active window is hpos 20..83, vpos 3..8 for this bench's parameters.
  always @(negedge clk) begin
    if (disp_en) begin
      if (hpos == 12'd20 && vpos == 11'd3) begin disp_pts++; check("disp_tl", 32'(display_on), 1); end
      if (hpos == 12'd83 && vpos == 11'd8) begin disp_pts++; check("disp_br", 32'(display_on), 1); end
      if (hpos == 12'd19 && vpos == 11'd3) begin disp_pts++; check("disp_hlo", 32'(display_on), 0); end
      if (hpos == 12'd84 && vpos == 11'd3) begin disp_pts++; check("disp_hhi", 32'(display_on), 0); end
      if (hpos == 12'd20 && vpos == 11'd2) begin disp_pts++; check("disp_vlo", 32'(display_on), 0); end
      if (hpos == 12'd20 && vpos == 11'd9) begin disp_pts++; check("disp_vhi", 32'(display_on), 0); end
    end
  end

  task automatic run_frame(input exp_t ex, input int short_line, input int vs_off,
                           input int rst_line, input int err_after);
    exp_q.push_back(ex);
    for (int ln = 0; ln < VT; ln++) begin
      int len;
      len = (ln == short_line) ? HT - 1 : HT;
      for (int x = 0; x < len; x++) begin
        @(negedge clk);
        hsync_in = (x < HSW) ? 1'b0 : 1'b1;
        if (ln == 0 && x == vs_off)   vsync_in = 1'b0;
        if (ln == VSW && x == vs_off) vsync_in = 1'b1;
        if (short_line >= 0 && ln == short_line + 1 && x == 6) begin
          check("short_locked", 32'(locked), 0);
          check("short_lock_err_cnt", 32'(lock_err_cnt), 32'(err_after));
        end
        if (ln == rst_line && x == 40) begin
          reset = 1'b0;
          #1;
          check_zero("midrst");
          repeat (3) @(negedge clk);
          reset = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(mk(0, 0, 0, 0), -1, 0, -1, 0);
    run_frame(mk(0, 0, 100, 12), -1, 0, -1, 0);
    run_frame(mk(0, 0, 100, 12), -1, 0, -1, 0);
    run_frame(mk(1, 0, 100, 12), -1, 0, -1, 0);
    disp_en = 1'b1;
    run_frame(mk(1, 0, 100, 12), -1, 0, -1, 0);
    disp_en = 1'b0;

    // One 99-clock line drops lock; four more boundaries reacquire it.
    run_frame(mk(1, 0, 100, 12), 5, 0, -1, 1);
    run_frame(mk(0, 1, 100, 12), -1, 0, -1, 0);
    run_frame(mk(0, 1, 100, 12), -1, 0, -1, 0);
    run_frame(mk(0, 1, 100, 12), -1, 0, -1, 0);
    run_frame(mk(1, 1, 100, 12), -1, 0, -1, 0);

    // vsync lagging hsync by 10 clocks still lands on the next line edge.
    run_frame(mk(1, 1, 100, 12), -1, 10, -1, 0);

    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (4200) @(negedge clk);
    check("timeout_hpos", 32'(hpos), 4095);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_lock_err_cnt", 32'(lock_err_cnt), 2);

    run_frame(mk(0, 2, 100, 12), -1, 0, -1, 0);
    run_frame(mk(0, 2, 100, 12), -1, 0, -1, 0);
    run_frame(mk(0, 2, 100, 12), -1, 0, -1, 0);
    run_frame(mk(1, 2, 100, 12), -1, 0, -1, 0);

    run_frame(mk(1, 2, 100, 12), -1, 0, 6, 0);
    run_frame(mk(0, 0, 0, 0), -1, 0, -1, 0);
    run_frame(mk(0, 0, 100, 12), -1, 0, -1, 0);
    run_frame(mk(0, 0, 100, 12), -1, 0, -1, 0);
    run_frame(mk(1, 0, 100, 12), -1, 0, -1, 0);

    repeat (10) @(negedge clk);
    check("records_drained", 32'(exp_q.size()), 0);
    check("disp_points_seen", 32'(disp_pts), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
